// File: rtl/unzoomer.sv
// unzoomer: divides signed screen coordinates by an unsigned zoom factor.
// The result is truncated toward zero, mapping pixel positions back to world space.
// Two restoring dividers, one per axis, each retire one quotient bit per cycle.
module unzoomer #(
  parameter int W = 8
) (
  input  logic         ACLK,
  input  logic         ARESETN,
  input  logic         ENB,
  input  logic         START,
  input  logic [W-1:0] Xcoord,
  input  logic [W-1:0] Ycoord,
  input  logic [W-1:0] Zoom,
  output logic         BUSY,
  output logic [W-1:0] Xout,
  output logic [W-1:0] Yout,
  output logic         VALID,
  output logic         ZERR
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sx_q, sx_d;
  logic           sy_q, sy_d;
  logic [W-1:0]   magX_q, magX_d;
  logic [W-1:0]   magY_q, magY_d;
  logic [W:0]     remX_q, remX_d;
  logic [W:0]     remY_q, remY_d;
  logic [W-1:0]   zoom_q, zoom_d;
  logic           busy_q, busy_d;
  logic           valid_q, valid_d;
  logic           zerr_q, zerr_d;
  logic [W-1:0]   xout_q, xout_d;
  logic [W-1:0]   yout_q, yout_d;

  logic [W:0]     remXShift, remYShift;
  logic           xGe, yGe;

  // Trial step of both dividers: bring in the next dividend bit and compare.
  always_comb begin
    remXShift = {remX_q[W-1:0], magX_q[W-1]};
    remYShift = {remY_q[W-1:0], magY_q[W-1]};
    xGe       = (remXShift >= {1'b0, zoom_q});
    yGe       = (remYShift >= {1'b0, zoom_q});
  end

  // Next-state and datapath: the magnitude registers double as quotient registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    magX_d  = magX_q;
    magY_d  = magY_q;
    remX_d  = remX_q;
    remY_d  = remY_q;
    zoom_d  = zoom_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    zerr_d  = zerr_q;
    xout_d  = xout_q;
    yout_d  = yout_q;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (START) begin
          if (Zoom != '0) begin
            sx_d    = Xcoord[W-1];
            sy_d    = Ycoord[W-1];
            magX_d  = Xcoord[W-1] ? -Xcoord : Xcoord;
            magY_d  = Ycoord[W-1] ? -Ycoord : Ycoord;
            zoom_d  = Zoom;
            remX_d  = '0;
            remY_d  = '0;
            cnt_d   = CW'(W - 1);
            busy_d  = 1'b1;
            state_d = DIV;
          end else begin
            valid_d = 1'b1;
            zerr_d  = 1'b1;
            xout_d  = '0;
            yout_d  = '0;
          end
        end
      end
      DIV: begin
        remX_d = xGe ? (remXShift - {1'b0, zoom_q}) : remXShift;
        remY_d = yGe ? (remYShift - {1'b0, zoom_q}) : remYShift;
        magX_d = {magX_q[W-2:0], xGe};
        magY_d = {magY_q[W-2:0], yGe};
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        xout_d  = sx_q ? -magX_q : magX_q;
        yout_d  = sy_q ? -magY_q : magY_q;
        valid_d = 1'b1;
        zerr_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers: async active-low reset, and ENB low freezes everything.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sx_q    <= 1'b0;
      sy_q    <= 1'b0;
      magX_q  <= '0;
      magY_q  <= '0;
      remX_q  <= '0;
      remY_q  <= '0;
      zoom_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      zerr_q  <= 1'b0;
      xout_q  <= '0;
      yout_q  <= '0;
    end else if (ENB) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      magX_q  <= magX_d;
      magY_q  <= magY_d;
      remX_q  <= remX_d;
      remY_q  <= remY_d;
      zoom_q  <= zoom_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      zerr_q  <= zerr_d;
      xout_q  <= xout_d;
      yout_q  <= yout_d;
    end
  end

  assign BUSY  = busy_q;
  assign VALID = valid_q;
  assign ZERR  = zerr_q;
  assign Xout  = xout_q;
  assign Yout  = yout_q;

endmodule

// File: tb/tb_unzoomer.sv
// tb_unzoomer: directed bench for unzoomer with a queue-based scoreboard.
// Expected quotients come from native signed division, which truncates toward zero.
module tb_unzoomer;

  localparam int W = 8;

  logic         ACLK;
  logic         ARESETN;
  logic         ENB;
  logic         START;
  logic [W-1:0] Xcoord;
  logic [W-1:0] Ycoord;
  logic [W-1:0] Zoom;
  logic         BUSY;
  logic [W-1:0] Xout;
  logic [W-1:0] Yout;
  logic         VALID;
  logic         ZERR;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         zerr;
  } exp_t;

  exp_t sb[$];
  int   nAsserts = 0;
  int   nFails   = 0;
  int   lat;

  unzoomer #(.W(W)) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .ENB     (ENB),
    .START   (START),
    .Xcoord  (Xcoord),
    .Ycoord  (Ycoord),
    .Zoom    (Zoom),
    .BUSY    (BUSY),
    .Xout    (Xout),
    .Yout    (Yout),
    .VALID   (VALID),
    .ZERR    (ZERR)
  );

  // Free-running clock, 10 time units per period.
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Reference quotient: signed coordinate over unsigned zoom, wrapped to W bits.
  function automatic logic [W-1:0] refDiv(input logic [W-1:0] c, input logic [W-1:0] z);
    int ci;
    int zi;
    ci = int'($signed(c));
    zi = int'(z);
    if (zi == 0) return '0;
    return W'(ci / zi);
  endfunction

  // Single comparison point; every check in the bench funnels through here.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp)
    else begin
      nFails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one request at a negedge, record its expectation, then drop START after E0.
  task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
    exp_t e;
    Xcoord = x;
    Ycoord = y;
    Zoom   = z;
    START  = 1'b1;
    e.x    = refDiv(x, z);
    e.y    = refDiv(y, z);
    e.zerr = (z == '0);
    sb.push_back(e);
    @(posedge ACLK);
    @(negedge ACLK);
    START = 1'b0;
  endtask

  // Step whole cycles until VALID is seen or the budget runs out; report edges used.
  task automatic waitValid(input int maxCycles, output int cycles);
    cycles = 0;
    while (VALID !== 1'b1 && cycles < maxCycles) begin
      @(posedge ACLK);
      @(negedge ACLK);
      cycles++;
    end
    check("validTimeout", {31'b0, VALID}, 32'd1);
  endtask

  // Pop the oldest expectation and compare it with the presented result.
  task automatic checkOutput(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sbEmpty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_Xout"}, {24'b0, Xout}, {24'b0, e.x});
      check({tag, "_Yout"}, {24'b0, Yout}, {24'b0, e.y});
      check({tag, "_ZERR"}, {31'b0, ZERR}, {31'b0, e.zerr});
    end
  endtask

  // Directed sequence covering reset, arithmetic corners, handshake, enable and abort.
  initial begin
    ARESETN = 1'b0;
    ENB     = 1'b1;
    START   = 1'b0;
    Xcoord  = '0;
    Ycoord  = '0;
    Zoom    = '0;
    #1;
    check("rstBusy",  {31'b0, BUSY},  32'd0);
    check("rstValid", {31'b0, VALID}, 32'd0);
    check("rstZerr",  {31'b0, ZERR},  32'd0);
    check("rstXout",  {24'b0, Xout},  32'd0);
    check("rstYout",  {24'b0, Yout},  32'd0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);

    $display("[TB] basic divide 100,-50 / 3");
    applyStimulus(8'd100, -8'sd50, 8'd3);
    check("t1BusyE0", {31'b0, BUSY}, 32'd1);
    waitValid(20, lat);
    check("t1Latency", lat, 32'd9);
    check("t1BusyE9", {31'b0, BUSY}, 32'd0);
    checkOutput("t1");
    @(posedge ACLK);
    @(negedge ACLK);
    check("t1ValidPulse", {31'b0, VALID}, 32'd0);
    check("t1XoutHold", {24'b0, Xout}, 32'h21);

    $display("[TB] magnitude corners");
    applyStimulus(8'h80, 8'd127, 8'd1);
    waitValid(20, lat);
    check("t2aLatency", lat, 32'd9);
    checkOutput("t2a");
    @(posedge ACLK);
    @(negedge ACLK);
    applyStimulus(-8'sd7, 8'd127, 8'd255);
    waitValid(20, lat);
    checkOutput("t2b");
    @(posedge ACLK);
    @(negedge ACLK);

    $display("[TB] divide by zero");
    applyStimulus(8'd5, 8'd3, 8'd0);
    check("t3BusyZ", {31'b0, BUSY}, 32'd0);
    waitValid(0, lat);
    checkOutput("t3");
    @(posedge ACLK);
    @(negedge ACLK);
    check("t3ValidPulse", {31'b0, VALID}, 32'd0);
    check("t3BusyNever", {31'b0, BUSY}, 32'd0);
    applyStimulus(8'd6, -8'sd6, 8'd2);
    waitValid(20, lat);
    checkOutput("t3b");
    @(posedge ACLK);
    @(negedge ACLK);

    $display("[TB] START held high, inputs disturbed while busy");
    begin
      exp_t e;
      Xcoord = 8'd10;
      Ycoord = 8'd20;
      Zoom   = 8'd2;
      START  = 1'b1;
      e.x = refDiv(8'd10, 8'd2);
      e.y = refDiv(8'd20, 8'd2);
      e.zerr = 1'b0;
      sb.push_back(e);
      @(posedge ACLK);
      @(negedge ACLK);
      check("t4BusyE0", {31'b0, BUSY}, 32'd1);
      Xcoord = -8'sd100;
      Ycoord = 8'd77;
      Zoom   = 8'd9;
      waitValid(20, lat);
      check("t4Latency1", lat, 32'd9);
      Xcoord = 8'd10;
      Ycoord = 8'd20;
      Zoom   = 8'd2;
      sb.push_back(e);
      checkOutput("t4a");
      @(posedge ACLK);
      @(negedge ACLK);
      check("t4Rearm", {31'b0, BUSY}, 32'd1);
      check("t4ValidOff", {31'b0, VALID}, 32'd0);
      Xcoord = 8'd55;
      Zoom   = 8'd1;
      waitValid(20, lat);
      check("t4Period", lat, 32'd9);
      START = 1'b0;
      checkOutput("t4b");
      @(posedge ACLK);
      @(negedge ACLK);
    end

    $display("[TB] enable freeze during DIV and during VALID");
    applyStimulus(8'd77, -8'sd33, 8'd5);
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    ENB = 1'b0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("t5BusyFrozen", {31'b0, BUSY}, 32'd1);
    check("t5ValidFrozen", {31'b0, VALID}, 32'd0);
    ENB = 1'b1;
    waitValid(20, lat);
    check("t5Remaining", lat, 32'd6);
    ENB = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge ACLK);
      @(negedge ACLK);
      check("t5ValidStretch", {31'b0, VALID}, 32'd1);
    end
    ENB = 1'b1;
    checkOutput("t5");
    @(posedge ACLK);
    @(negedge ACLK);
    check("t5ValidEnd", {31'b0, VALID}, 32'd0);

    $display("[TB] asynchronous reset mid-operation");
    applyStimulus(8'd50, 8'd50, 8'd3);
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    #2;
    ARESETN = 1'b0;
    #1;
    check("t6Busy",  {31'b0, BUSY},  32'd0);
    check("t6Valid", {31'b0, VALID}, 32'd0);
    check("t6Xout",  {24'b0, Xout},  32'd0);
    check("t6Yout",  {24'b0, Yout},  32'd0);
    sb.delete();
    @(negedge ACLK);
    ARESETN = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge ACLK);
      @(negedge ACLK);
      check("t6NoValid", {31'b0, VALID}, 32'd0);
    end
    applyStimulus(-8'sd9, 8'd9, 8'd4);
    waitValid(20, lat);
    check("t6Latency", lat, 32'd9);
    checkOutput("t6");
    @(posedge ACLK);
    @(negedge ACLK);

    check("sbDrained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
